// File: rtl/jpeg_maj_carry_pipe.sv
// rtl/jpeg_maj_carry_pipe.sv - pipelined MAJ carry-chain adder/comparator with valid/ready flow
module jpeg_maj_carry_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ge
);
  localparam int L = WIDTH / STAGES;

  // per-stage valid, carry and compare-mode bits
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] m_q, m_d;
  logic [STAGES-1:0] adv;

  // per-stage operand A, prepared operand B' and partially computed sum
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;

  // comb temporaries
  logic             full_t;
  logic             carry_t;
  logic [WIDTH-1:0] bp_t;
  logic [WIDTH-1:0] s_t;

  // A stage may load unless it and every stage below it are full and the output is stalled
  always_comb begin
    adv    = '0;
    full_t = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_t = full_t & v_q[k];
      adv[k] = !full_t || out_ready;
    end
  end

  // Ripple one L-bit MAJ slice per stage; stage 0 works straight off the input operands
  always_comb begin
    v_d     = v_q;
    c_d     = c_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_t = 1'b0;
    bp_t    = '0;
    s_t     = '0;

    if (adv[0]) begin
      bp_t    = mode ? ~b : b;
      carry_t = mode ? 1'b1 : cin;
      s_t     = '0;
      for (int j = 0; j < L; j++) begin
        s_t[j]  = a[j] ^ bp_t[j] ^ carry_t;
        carry_t = (a[j] & bp_t[j]) | (a[j] & carry_t) | (bp_t[j] & carry_t);
      end
      v_d[0] = in_valid;
      a_d[0] = a;
      b_d[0] = bp_t;
      s_d[0] = s_t;
      c_d[0] = carry_t;
      m_d[0] = mode;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        s_t     = s_q[k-1];
        carry_t = c_q[k-1];
        for (int j = 0; j < L; j++) begin
          s_t[k*L+j] = a_q[k-1][k*L+j] ^ b_q[k-1][k*L+j] ^ carry_t;
          carry_t    = (a_q[k-1][k*L+j] & b_q[k-1][k*L+j]) |
                       (a_q[k-1][k*L+j] & carry_t) |
                       (b_q[k-1][k*L+j] & carry_t);
        end
        v_d[k] = v_q[k-1];
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
        s_d[k] = s_t;
        c_d[k] = carry_t;
        m_d[k] = m_q[k-1];
      end
    end
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      m_q <= m_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ge        = m_q[STAGES-1] & c_q[STAGES-1];

endmodule

// File: tb/tb_jpeg_maj_carry_pipe.sv
// tb/tb_jpeg_maj_carry_pipe.sv - table-driven and sequence bench for jpeg_maj_carry_pipe
module tb_jpeg_maj_carry_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ge;

  jpeg_maj_carry_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ge(ge)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;
    logic [15:0] s;
    logic        co;
    logic        g;
  } vec_t;

  vec_t        tv [10];
  logic [17:0] exp_q [$];
  logic [17:0] next_exp;
  logic [17:0] prev_res;
  logic        stall_prev = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          popped = 0;

  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic md);
    logic [16:0] r;
    if (md) r = {1'b0, av} + {1'b0, ~bv} + 17'd1;
    else    r = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    return {md & r[16], r};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic md);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = ci;
    mode     = md;
    next_exp = model(av, bv, ci, md);
  endtask

  // one clock: sample mid-cycle, score transfers, then step to just after the next edge
  task automatic cycle(input int exp_rdy);
    logic [17:0] e;
    #4;
    if (exp_rdy >= 0) check("in_ready", {17'd0, in_ready}, 18'(exp_rdy));
    if (stall_prev) begin
      check("hold_valid", {17'd0, out_valid}, 18'd1);
      check("hold_data", {ge, cout, sum}, prev_res);
    end
    if (out_valid && out_ready) begin
      popped++;
      if (exp_q.size() == 0) check("spurious_out", {17'd0, out_valid}, 18'd0);
      else begin
        e = exp_q.pop_front();
        check("result", {ge, cout, sum}, e);
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_res   = {ge, cout, sum};
    if (in_valid && in_ready) exp_q.push_back(next_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          p0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];

    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    tv[2] = '{16'h1233, 16'h1234, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tv[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0};
    tv[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[6] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tv[7] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
    tv[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[9] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    out_ready = 1'b0; next_exp = '0; prev_res = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {17'd0, out_valid}, 18'd0);
    check("rst_fields", {ge, cout, sum}, 18'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {17'd0, in_ready}, 18'd1);

    // single transaction latency: visible after the 4th edge, for one cycle only
    out_ready = 1'b1;
    drive(1'b1, tv[0].a, tv[0].b, tv[0].cin, tv[0].mode);
    next_exp = {tv[0].g, tv[0].co, tv[0].s};
    cycle(1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("latency_valid", {17'd0, out_valid}, {17'd0, (i == 3)});
      cycle(-1);
    end
    check("one_cycle_valid", {17'd0, out_valid}, 18'd0);

    // table vectors back to back
    p0 = popped;
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, tv[n].a, tv[n].b, tv[n].cin, tv[n].mode);
      next_exp = {tv[n].g, tv[n].co, tv[n].s};
      cycle(1);
    end
    in_valid = 1'b0;
    repeat (6) cycle(-1);
    check("table_count", 18'(popped - p0), 18'd10);
    check("table_drained", 18'(exp_q.size()), 18'd0);

    // streaming random traffic
    p0 = popped;
    for (int n = 0; n < 100; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive(1'b1, ra, rb, 1'($urandom), 1'($urandom));
      cycle(1);
    end
    in_valid = 1'b0;
    repeat (6) cycle(-1);
    check("stream_count", 18'(popped - p0), 18'd100);
    check("stream_drained", 18'(exp_q.size()), 18'd0);

    // backpressure: four accepted, fifth waits for out_ready
    for (int n = 0; n < 5; n++) begin
      bp_a[n] = 16'($urandom);
      bp_b[n] = 16'($urandom);
    end
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, bp_a[n], bp_b[n], 1'b1, n[0]);
      cycle((n < 4) ? 1 : 0);
    end
    check("bp_accepted", 18'(exp_q.size()), 18'd4);
    for (int n = 0; n < 3; n++) begin
      check("bp_front_valid", {17'd0, out_valid}, 18'd1);
      check("bp_front_data", {ge, cout, sum}, exp_q[0]);
      cycle(0);
    end
    out_ready = 1'b1;
    cycle(1);
    in_valid = 1'b0;
    repeat (6) cycle(-1);
    check("bp_drained", 18'(exp_q.size()), 18'd0);

    // bubbles with random output stalls
    p0 = popped;
    for (int cyc = 0; cyc < 32; cyc++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      out_ready = 1'($urandom);
      drive((cyc % 4) != 1, ra, rb, 1'($urandom), 1'($urandom));
      cycle(-1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle(-1);
    check("bubble_drained", 18'(exp_q.size()), 18'd0);

    // reset with three transactions in flight
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 16'hFFFF, 16'(n + 1), 1'b1, 1'b0);
      cycle(1);
    end
    in_valid = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {17'd0, out_valid}, 18'd0);
    check("async_rst_fields", {ge, cout, sum}, 18'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle(1);
    repeat (7) cycle(-1);
    check("no_stale_valid", {17'd0, out_valid}, 18'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_maj_carry_pipe.md
# jpeg_maj_carry_pipe

Parametrised, pipelined majority-gate carry chain for the JPEG datapath. It generalises the fixed-length MAJ ripple chain with its final XOR into a WIDTH-bit adder/comparator split into STAGES register stages. Each transaction uses a valid/ready handshake and produces the full sum, carry-out and a compare flag. It sits between the quantiser-side operand muxes and the entropy-coder magnitude logic.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline register stages; must divide WIDTH exactly. Slice width is L = WIDTH/STAGES.
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an operand set is present.
- in_ready  output  1  the block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when mode=1.
- mode  input  1  0 selects add (A+B+cin); 1 selects unsigned compare/subtract (A+~B+1).
- out_valid  output  1  a result is present.
- out_ready  input  1  the consumer accepts the result.
- sum  output  WIDTH  sum, i.e. (A+B'+c) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ge  output  1  equals cout when mode=1 (A ≥ B unsigned); 0 when mode=0.

## Operation
- Transfer rules: an input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Operand preparation on capture:
  - B' = mode ? ~b : b.
  - c0 = mode ? 1 : cin.
- Stage k (0..STAGES-1) holds v[k], a carry register, the not-yet-processed upper bits of A and B', and the sum bits already computed.
- Each stage evaluates one ripple slice with MAJ cells:
  - c[i+1] = MAJ(a[i], b'[i], c[i]).
  - s[i] = a[i] ^ b'[i] ^ c[i].
  - The slice covers bits k·L .. k·L+L-1.
- Stage 0 processes slice 0 combinationally from the input operands and registers the result into stage 0.
- Stage k>0 processes slice k from stage k-1's registered contents.
- The last stage drives sum, cout, ge and out_valid = v[STAGES-1].
- Advance rule, evaluated per stage:
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0].
- On a stage enable, the stage loads the upstream contents and the upstream valid. A stage with v=0 may hold stale data; data regs need not be cleared.
- The pipeline holds at most STAGES transactions. Bubbles collapse while the output is stalled.
- Result fields are taken from the registered last stage only. The outputs contain no combinational path from a, b or cin.

## Timing
- Reset (async assert, sync-safe release):
  - All v[k]=0, so out_valid=0.
  - sum=0, cout=0, ge=0; data registers are reset to 0.
  - in_ready=1 on the first cycle after reset release.
- Latency: a transfer accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages.
- Throughput: 1 transaction per cycle while out_ready=1.
- Full pipeline: with all v[k]=1 and out_ready=0, in_ready=0 in the same cycle (combinational through the adv chain).
- Simultaneous events:
  - With the pipeline full and out_ready=1, a new input is accepted in the same cycle.
  - Data shifts in the same cycle, with no bubble inserted.
- Output stability: while out_valid=1 && out_ready=0, sum, cout and ge hold stable.
- Reset mid-operation: all in-flight transactions are discarded. No partial result is ever presented.
- Wrap-around: the sum is truncated mod 2^WIDTH; the overflow shows only in cout.

## Test plan
1. Reset, then add with WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, mode=0, out_ready=1 -> after 4 edges, out_valid=1, sum=0x0000, cout=1, ge=0, for exactly one cycle.
2. Compare: a=0x1234, b=0x1234, mode=1 -> sum=0x0000, cout=1, ge=1. Then a=0x1233, b=0x1234 -> sum=0xFFFF, cout=0, ge=0.
3. Streaming: 100 random back-to-back operand sets with out_ready=1 -> in_ready stays 1. Results arrive in order, one per cycle, and match the reference model.
4. Backpressure: out_ready=0 while 5 transactions are offered -> 4 are accepted, then in_ready=0. The output holds result #1 stable. Raising out_ready drains the results in order with the 5th accepted in the same cycle.
5. Bubbles: inputs on cycles 0, 2, 3 with out_ready toggling randomly -> no loss, duplication or reorder. Carry-in edge case: a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0.
6. Reset asserted with 3 transactions in flight -> out_valid=0 and sum/cout/ge=0 immediately (asynchronously). After release, no stale result appears.
